// File: rtl/gauss3x3_stream.sv
// gauss3x3_stream
// Streaming 3x3 Gaussian smoothing (kernel 1 2 1 / 2 4 2 / 1 2 1, /16) over a
// raster-order 8-bit pixel stream. Two line buffers plus a 3x3 window give a
// single-pass filter. Only interior pixels are emitted: one output per accepted
// pixel with row>=2 and col>=2, for the centre (col-1,row-1), 2 cycles later.
//
// Optional build macro:
//   GAUSS_ROUND_EN  defined   -> pix_out = (sum+8)>>4 (round half up)
//                   undefined -> pix_out = sum>>4      (truncate)
//
// Ports:
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   pix_in         input pixel, raster order
//   pix_in_valid   pix_in accepted on this rising edge
//   sof            with pix_in_valid: accepted pixel is (0,0)
//   pix_out        filtered pixel
//   pix_out_valid  pix_out valid this cycle
//   frame_done     pulses with the output for centre (IMG_W-2, IMG_H-2)
module gauss3x3_stream #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pix_in,
  input  logic       pix_in_valid,
  input  logic       sof,
  output logic [7:0] pix_out,
  output logic       pix_out_valid,
  output logic       frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col, col_eff;
  logic [RW-1:0] row, row_eff;

  // Line buffers: lb1 holds row-1, lb2 holds row-2, indexed by column.
  logic [7:0] lb1 [IMG_W];
  logic [7:0] lb2 [IMG_W];

  // Window columns, index 2 is the newest (current col), 0 the oldest.
  logic [7:0] w_top [3];
  logic [7:0] w_mid [3];
  logic [7:0] w_bot [3];

  logic        v0, last0;
  logic        v1, last1;
  logic [11:0] sum_c, sum1;
  logic [7:0]  q_c;

  // sof forces the accepted pixel to (0,0); counters continue from there.
  always_comb begin
    col_eff = col;
    row_eff = row;
    if (sof) begin
      col_eff = '0;
      row_eff = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pix_in_valid) begin
      if (col_eff == COL_LAST) begin
        col <= '0;
        row <= (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
      end else begin
        col <= col_eff + 1'b1;
        row <= row_eff;
      end
    end
  end

  // Line buffers and window are data-path storage only; no reset needed.
  always_ff @(posedge clk) begin
    if (pix_in_valid) begin
      lb1[col_eff] <= pix_in;
      lb2[col_eff] <= lb1[col_eff];
      for (int unsigned i = 0; i < 2; i++) begin
        w_top[i] <= w_top[i+1];
        w_mid[i] <= w_mid[i+1];
        w_bot[i] <= w_bot[i+1];
      end
      w_top[2] <= lb2[col_eff];
      w_mid[2] <= lb1[col_eff];
      w_bot[2] <= pix_in;
    end
  end

  // Stage 0 flags travel alongside the window update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0    <= 1'b0;
      last0 <= 1'b0;
    end else begin
      v0    <= pix_in_valid && (row_eff >= ROW_TWO) && (col_eff >= COL_TWO);
      last0 <= pix_in_valid && (row_eff == ROW_LAST) && (col_eff == COL_LAST);
    end
  end

  always_comb begin
    sum_c = 12'(w_top[0]) + {3'b0, w_top[1], 1'b0} + 12'(w_top[2])
          + {3'b0, w_mid[0], 1'b0} + {2'b0, w_mid[1], 2'b0} + {3'b0, w_mid[2], 1'b0}
          + 12'(w_bot[0]) + {3'b0, w_bot[1], 1'b0} + 12'(w_bot[2]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum1  <= '0;
      v1    <= 1'b0;
      last1 <= 1'b0;
    end else begin
      sum1  <= sum_c;
      v1    <= v0;
      last1 <= last0;
    end
  end

  // Max sum is 4080, so sum+8 still fits in 12 bits.
  always_comb begin
`ifdef GAUSS_ROUND_EN
    q_c = 8'((sum1 + 12'd8) >> 4);
`else
    q_c = 8'(sum1 >> 4);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out       <= '0;
      pix_out_valid <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      pix_out_valid <= v1;
      frame_done    <= last1;
      if (v1) pix_out <= q_c;
    end
  end

endmodule
